instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage that sits between the program counter block and the instruction decoder.
- Each instruction fetch is a read of instruction memory at the current PC, using a req/ack handshake with variable latency.
- Returned words are buffered in a small FIFO, together with the PC they came from.
- Pulses pc_en so the PC block advances; a PCSrc redirect flushes the FIFO and any in-flight fetch.

Parameters:
AW, 8, PC / instruction-memory address width
IW, 16, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
PC  input  AW  current program counter from PC block
PCSrc  input  1  redirect/branch taken; flush this cycle
pc_en  output  1  one-cycle pulse: PC block advances to next address
mem_req  output  1  instruction memory read request
mem_addr  output  AW  read address, captured from PC when request is issued
mem_ack  input  1  memory response valid; mem_rdata valid same cycle
mem_rdata  input  IW  instruction word
instr  output  IW  FIFO head instruction
instr_pc  output  AW  PC of FIFO head
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decoder accepts head when instr_valid & instr_ready

Behaviour:
- Reset (async, reset_n=0): state=IDLE; FIFO empty; mem_req=0, mem_addr=0, pc_en=0, instr_valid=0, instr=0, instr_pc=0.
- FSM states: IDLE, REQ, DROP.
- IDLE -> REQ when FIFO count < DEPTH and PCSrc=0.
  - Registers mem_addr<=PC and mem_req<=1; the request is visible the next cycle.
- REQ: mem_req and mem_addr held stable until mem_ack.
  - mem_ack=1 and PCSrc=0: push {mem_addr, mem_rdata}; pc_en=1 for that one cycle (registered, high in the cycle after the ack); mem_req<=0; go to IDLE.
  - mem_ack=1 and PCSrc=1: discard the data, no push, no pc_en; go to IDLE.
  - mem_ack=0 and PCSrc=1: go to DROP; mem_req stays high, because a request is never withdrawn.
- DROP: mem_req held; on mem_ack, discard the data and go to IDLE. PCSrc in DROP has no further effect.
- Only one request is outstanding at a time. Minimum fetch period is 3 cycles (issue, ack, pc_en/PC update).
- A new request is never issued in the cycle pc_en is high, so mem_addr always samples the updated PC.
- FIFO: push on an accepted response; pop on instr_valid & instr_ready. Simultaneous push and pop in the same cycle leaves count unchanged.
  - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Full (count==DEPTH): no request is issued. A request already in flight is only issued when count<DEPTH, so a push never overflows.
- Empty: instr_valid=0. instr/instr_pc hold their last values and are don't-care.
- PCSrc=1 in any state empties the FIFO next cycle, including any pop in the same cycle. instr_valid=0 in the following cycle.
- Reset asserted mid-request: immediately IDLE and mem_req=0. Memory must tolerate an abandoned request.

Optional Feature:
- Macro IFETCH_STATS_EN.
- When defined, adds outputs fetch_count (16b) and flush_count (16b). Both reset to 0 and saturate at 16'hFFFF.
  - fetch_count increments on each FIFO push.
  - flush_count increments on each cycle where PCSrc=1 discards at least one FIFO entry or an in-flight response.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then PC=0, mem_ack one cycle after each req with rdata=16'h1000+addr, instr_ready=1 -> mem_addr sequence 0,1,2,3, one pc_en per fetch, instr/instr_pc = 16'h1000/0, 16'h1001/1, ...
- instr_ready=0, memory always acks -> exactly 4 pushes, then mem_req stays 0 with instr_valid=1. Raise instr_ready -> entries drain in order 0..3 and fetching resumes at PC=4.
- Issue req at PC=5 with mem_ack delayed 3 cycles; pulse PCSrc=1 with PC=50 in the 2nd wait cycle -> mem_req held until ack, data discarded, no pc_en, next mem_addr=50.
- FIFO holds 3 entries; PCSrc=1 coincides with mem_ack and instr_ready -> no push, FIFO empty next cycle, instr_valid=0.
- Drop reset_n low while mem_req=1 and FIFO holds 2 entries -> mem_req=0 and instr_valid=0 asynchronously. After release, fetch restarts from the current PC.
- IFETCH_STATS_EN defined: 6 fetches plus 1 flush of a non-empty FIFO -> fetch_count=6, flush_count=1.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack fetch FSM feeding a prefetch FIFO of {pc, instr} pairs.
// Optional IFETCH_STATS_EN adds saturating fetch_count / flush_count outputs.
module instr_fetch #(
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic [AW-1:0] PC,
  input  logic          PCSrc,
  output logic          pc_en,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0]   fetch_count,
  output logic [15:0]   flush_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e state_q, state_d;

  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic          pc_en_q;

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic issue, push, pop, flush;

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (issue) state_d = StReq;
      StReq: begin
        if (mem_ack) begin
          state_d = StIdle;
        end else if (PCSrc) begin
          state_d = StDrop;
        end
      end
      StDrop: if (mem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control decode; holding off while pc_en is high guarantees mem_addr sees the advanced PC
  always_comb begin
    issue = (state_q == StIdle) && (count_q < FullCount) && !PCSrc && !pc_en_q;
    push  = (state_q == StReq) && mem_ack && !PCSrc;
    pop   = instr_valid && instr_ready;
    flush = PCSrc;
  end

  // Memory interface and PC advance pulse
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_en_q    <= 1'b0;
    end else begin
      pc_en_q <= push;
      if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= PC;
      end else if ((state_q != StIdle) && mem_ack) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  // Prefetch FIFO; a flush overrides any same-cycle pop
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr_q] <= mem_rdata;
        pc_mem[wr_ptr_q]    <= mem_addr_q;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign pc_en       = pc_en_q;
  assign instr       = instr_mem[rd_ptr_q];
  assign instr_pc    = pc_mem[rd_ptr_q];
  assign instr_valid = (count_q != '0);

`ifdef IFETCH_STATS_EN
  logic discard;
  // A flush only counts when it throws away buffered or about-to-arrive work
  assign discard = PCSrc && ((count_q != '0) || (state_q == StReq));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (discard && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
